// File: rtl/decode_pipe_stage.sv
// Decode stage: decodes RV32 ALU instructions into a compact record on
// acceptance and buffers the records in a small FIFO ahead of the consumer.
module decode_pipe_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [4:0]       alu_control,
    output logic [XLEN-1:0]  imm,
    output logic             use_imm,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Processor-wide ALU operation codes
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    localparam logic [6:0] OP_R = 7'h33;
    localparam logic [6:0] OP_I = 7'h13;

    localparam int unsigned   PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      alu;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
    } rec_t;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    rec_t       dec;
    logic       bad;

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             alive;
    logic             push;
    logic             pop;
    rec_t             head;

    assign opcode = instr_in[6:0];
    assign func3  = instr_in[14:12];
    assign func7  = instr_in[31:25];

    // Decode the incoming word into a record; unsupported encodings collapse to a zeroed illegal record
    always_comb begin
        dec     = '0;
        dec.alu = ALU_ADD;
        bad     = 1'b0;
        case (opcode)
            OP_R: begin
                dec.rs1 = instr_in[19:15];
                dec.rs2 = instr_in[24:20];
                dec.rd  = instr_in[11:7];
                if (func7 == 7'h00) begin
                    case (func3)
                        3'd0: dec.alu = ALU_ADD;
                        3'd1: dec.alu = ALU_SLL;
                        3'd2: dec.alu = ALU_SLT;
                        3'd3: dec.alu = ALU_SLTU;
                        3'd4: dec.alu = ALU_XOR;
                        3'd5: dec.alu = ALU_SRL;
                        3'd6: dec.alu = ALU_OR;
                        3'd7: dec.alu = ALU_AND;
                    endcase
                end else if (func7 == 7'h20 && func3 == 3'd0) begin
                    dec.alu = ALU_SUB;
                end else if (func7 == 7'h20 && func3 == 3'd5) begin
                    dec.alu = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_I: begin
                dec.rs1     = instr_in[19:15];
                dec.rd      = instr_in[11:7];
                dec.use_imm = 1'b1;
                dec.imm     = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
                case (func3)
                    3'd0: dec.alu = ALU_ADD;
                    3'd2: dec.alu = ALU_SLT;
                    3'd3: dec.alu = ALU_SLTU;
                    3'd4: dec.alu = ALU_XOR;
                    3'd6: dec.alu = ALU_OR;
                    3'd7: dec.alu = ALU_AND;
                    3'd1: begin
                        dec.imm = {{(XLEN-5){1'b0}}, instr_in[24:20]};
                        if (func7 == 7'h00) dec.alu = ALU_SLL;
                        else                bad     = 1'b1;
                    end
                    3'd5: begin
                        dec.imm = {{(XLEN-5){1'b0}}, instr_in[24:20]};
                        if (func7 == 7'h00)      dec.alu = ALU_SRL;
                        else if (func7 == 7'h20) dec.alu = ALU_SRA;
                        else                     bad     = 1'b1;
                    end
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec         = '0;
            dec.alu     = ALU_ADD;
            dec.illegal = 1'b1;
        end
    end

    // Handshakes depend only on registered state; alive keeps in_ready low until the first edge out of reset
    assign in_ready  = alive && (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Record storage, written at the tail on every accepted instruction
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Pointers, occupancy, ready enable and saturating illegal-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            alive       <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            alive <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (push && dec.illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // Present the head record, forcing all data outputs to zero while empty
    always_comb begin
        head = '0;
        if (out_valid) head = mem[rd_ptr];
    end

    assign rs1         = head.rs1;
    assign rs2         = head.rs2;
    assign rd          = head.rd;
    assign alu_control = head.alu;
    assign imm         = head.imm;
    assign use_imm     = head.use_imm;
    assign illegal     = head.illegal;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed bench for decode_pipe_stage with a queue of expected head records.
module tb_decode_pipe_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    localparam logic [4:0] ADD  = 5'd0;
    localparam logic [4:0] SUB  = 5'd1;
    localparam logic [4:0] SLL  = 5'd2;
    localparam logic [4:0] SLT  = 5'd3;
    localparam logic [4:0] SLTU = 5'd4;
    localparam logic [4:0] XOR_ = 5'd5;
    localparam logic [4:0] SRL  = 5'd6;
    localparam logic [4:0] SRA  = 5'd7;
    localparam logic [4:0] OR_  = 5'd8;
    localparam logic [4:0] AND_ = 5'd9;

    typedef struct {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      alu;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            illegal;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr_in;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       rs1, rs2, rd, alu_control;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    decode_pipe_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .out_valid(out_valid), .out_ready(out_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control), .imm(imm),
        .use_imm(use_imm), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input logic [4:0] a, input logic [31:0] im, input logic ui,
                                input logic il);
        exp_t e;
        e.rs1 = r1; e.rs2 = r2; e.rd = d; e.alu = a; e.imm = im; e.use_imm = ui; e.illegal = il;
        return e;
    endfunction

    function automatic exp_t ill();
        return mk(5'd0, 5'd0, 5'd0, ADD, 32'd0, 1'b0, 1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // compare current head outputs against the front of the scoreboard (no pop)
    task automatic cmp_head(input string tag);
        exp_t e;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb[0];
            chk({tag, ".rs1"}, 64'(rs1), 64'(e.rs1));
            chk({tag, ".rs2"}, 64'(rs2), 64'(e.rs2));
            chk({tag, ".rd"}, 64'(rd), 64'(e.rd));
            chk({tag, ".alu"}, 64'(alu_control), 64'(e.alu));
            chk({tag, ".imm"}, 64'(imm), 64'(e.imm));
            chk({tag, ".use_imm"}, 64'(use_imm), 64'(e.use_imm));
            chk({tag, ".illegal"}, 64'(illegal), 64'(e.illegal));
        end
    endtask

    task automatic push(input logic [31:0] w, input exp_t e);
        chk("push.in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        instr_in = w;
        tick();
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    // bounded wait for a valid head, compare it, then pop it
    task automatic pop_check(input string tag);
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        cmp_head(tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".rs1"}, 64'(rs1), 64'd0);
        chk({tag, ".rd"}, 64'(rd), 64'd0);
        chk({tag, ".alu"}, 64'(alu_control), 64'd0);
        chk({tag, ".imm"}, 64'(imm), 64'd0);
        chk({tag, ".illegal"}, 64'(illegal), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] r_alu [8];
        logic [31:0] w;
        r_alu[0] = ADD; r_alu[1] = SLL; r_alu[2] = SLT; r_alu[3] = SLTU;
        r_alu[4] = XOR_; r_alu[5] = SRL; r_alu[6] = OR_; r_alu[7] = AND_;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr_in = '0;
        #2;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk_empty("rst");
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);
        chk_empty("post_rst");

        // R-type ADD, one-cycle latency into an empty buffer
        push(32'h002081B3, mk(5'd1, 5'd2, 5'd3, ADD, 32'd0, 1'b0, 1'b0));
        chk("lat.out_valid", 64'(out_valid), 64'd1);
        pop_check("add");
        chk_empty("after_add");

        // fill, full stalls input, pop while full accepts nothing
        push(32'h407302B3, mk(5'd6, 5'd7, 5'd5, SUB, 32'd0, 1'b0, 1'b0));
        push(32'hFFF00093, mk(5'd0, 5'd0, 5'd1, ADD, 32'hFFFFFFFF, 1'b1, 1'b0));
        chk("full.in_ready", 64'(in_ready), 64'd0);
        tick();
        cmp_head("stable_sub");
        in_valid = 1'b1;
        instr_in = 32'h002081B3;
        pop_check("sub");
        in_valid = 1'b0;
        chk("after_full_pop.in_ready", 64'(in_ready), 64'd1);
        pop_check("addi_neg");
        chk_empty("after_addi");

        // I-type arithmetic shift
        push(32'h40325213, mk(5'd4, 5'd0, 5'd4, SRA, 32'd3, 1'b1, 1'b0));
        pop_check("srai");
        // I-type logical shift left and ORI with positive immediate
        push(32'h00511093, mk(5'd2, 5'd0, 5'd1, SLL, 32'd5, 1'b1, 1'b0));
        push(32'h07F1E113, mk(5'd3, 5'd0, 5'd2, OR_, 32'h7F, 1'b1, 1'b0));
        pop_check("slli");
        pop_check("ori");

        // illegal decodes and counter saturation (CNT_W=2, max 3)
        push(32'h0000007F, ill());
        push(32'h60000033, ill());
        chk("ill.cnt2", 64'(illegal_cnt), 64'd2);
        pop_check("ill_opcode");
        pop_check("ill_func7");
        push(32'h40321213, ill());
        chk("ill.cnt3", 64'(illegal_cnt), 64'd3);
        pop_check("ill_shift");
        push(32'h02000033, ill());
        chk("ill.cnt_sat", 64'(illegal_cnt), 64'd3);
        pop_check("ill_sat");

        // streaming at count=1 with simultaneous push and pop
        push(32'h00000013, mk(5'd0, 5'd0, 5'd0, ADD, 32'd0, 1'b1, 1'b0));
        for (int i = 0; i < 10; i++) begin
            w = {7'h00, 5'(i + 3), 5'(i + 2), 3'(i), 5'(i + 1), 7'h33};
            in_valid  = 1'b1;
            out_ready = 1'b1;
            instr_in  = w;
            cmp_head($sformatf("stream%0d", i));
            tick();
            if (sb.size() != 0) void'(sb.pop_front());
            sb.push_back(mk(5'(i + 2), 5'(i + 3), 5'(i + 1), r_alu[i % 8], 32'd0, 1'b0, 1'b0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream.in_ready", 64'(in_ready), 64'd1);
        cmp_head("stream_last");

        // mid-stream reset discards entries and clears the counter immediately
        in_valid = 1'b1;
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        chk("midrst.illegal_cnt", 64'(illegal_cnt), 64'd0);
        chk_empty("midrst");
        in_valid = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rerun.in_ready", 64'(in_ready), 64'd1);
        chk_empty("rerun");
        push(32'h0020F1B3, mk(5'd1, 5'd2, 5'd3, AND_, 32'd0, 1'b0, 1'b0));
        pop_check("rerun_and");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32: width of the sign-extended immediate output.
REQ-002 SHALL provide parameter DEPTH, default 2: decoded-entry buffer depth; power of two, at least 2.
REQ-003 SHALL provide parameter CNT_W, default 16: width of the illegal-instruction counter.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1: instr_in is valid this cycle.
REQ-008 Port in_ready, output, 1: the stage can accept an instruction.
REQ-009 Port instr_in, input, 32: full RV32 instruction word.
REQ-010 Port out_valid, output, 1: the head entry is valid.
REQ-011 Port out_ready, input, 1: the consumer takes the head entry.
REQ-012 Port rs1, rs2 and rd, output, 5 each: register indices of the head entry.
REQ-013 Port alu_control, output, 5: ALU operation code, taken from the processor-wide ALU macros (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
REQ-014 Port imm, output, XLEN: sign-extended I-type immediate; 0 for R-type.
REQ-015 Port use_imm, output, 1: operand B is imm rather than rs2.
REQ-016 Port illegal, output, 1: the head entry is not a supported instruction.
REQ-017 Port illegal_cnt, output, CNT_W: count of illegal instructions accepted.

Function
REQ-018 SHALL decode instr_in combinationally on acceptance and store the decoded record (rs1, rs2, rd, alu_control, imm, use_imm, illegal) in a DEPTH-entry FIFO; instr_in itself is not stored.
REQ-019 Field extraction: rd=[11:7], func3=[14:12], rs1=[19:15], rs2=[24:20], func7=[31:25], opcode=[6:0].
REQ-020 R-type (opcode 0x33): func7=0x00 maps func3 0..7 to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; func7=0x20 with func3=0 gives SUB; func7=0x20 with func3=5 gives SRA; any other func7/func3 combination is illegal; use_imm=0.
REQ-021 I-type ALU (opcode 0x13): func3 0,2,3,4,6,7 give ADD, SLT, SLTU, XOR, OR, AND (never SUB); rs2=0; use_imm=1; imm={sign-extend [31:20]}.
REQ-022 I-type shifts: func3=1 with func7=0x00 gives SLL; func3=5 with func7=0x00 gives SRL; func3=5 with func7=0x20 gives SRA; any other func7 for a shift is illegal; imm={zeros, [24:20]}.
REQ-023 Any other opcode, and any illegal case, SHALL store: illegal=1, alu_control=ADD, rs1=rs2=rd=0, imm=0, use_imm=0.
REQ-024 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-025 in_ready = (count < DEPTH), registered-state only; no combinational path from out_ready to in_ready, so a full buffer accepts nothing even if a pop occurs that cycle.
REQ-026 out_valid = (count != 0); the head record drives the outputs; when empty, all data outputs SHALL be 0.
REQ-027 Latency: an instruction pushed into an empty buffer SHALL appear with out_valid=1 on the next cycle.
REQ-028 A simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-030 Head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-031 illegal_cnt SHALL increment by 1 on each push whose decode is illegal, and SHALL saturate at 2^CNT_W-1.

Reset
REQ-032 rst_n low SHALL immediately clear count, pointers and illegal_cnt, giving out_valid=0, in_ready=0 while rst_n is low, and all data outputs 0.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge; a reset asserted mid-operation SHALL discard all buffered entries.

Verification
REQ-034 Push 0x002081B3 into an empty buffer -> next cycle: out_valid=1, rs1=1, rs2=2, rd=3, alu_control=ADD, use_imm=0, illegal=0.
REQ-035 Push 0x407302B3 then 0xFFF00093 with out_ready=0 -> in_ready=0 after two pushes. Then pop twice -> first SUB with rs1=6, rs2=7, rd=5; then ADD with use_imm=1, imm=0xFFFFFFFF, rd=1.
REQ-036 Push 0x40325213 -> alu_control=SRA, rs1=4, rd=4, imm=3, use_imm=1.
REQ-037 Push 0x0000007F, then 0x60000033 -> both entries illegal=1, alu_control=ADD, illegal_cnt=2; force illegal_cnt to its max value, push another illegal instruction -> illegal_cnt stays at 2^CNT_W-1.
REQ-038 With count=1, hold in_valid=1 and out_ready=1 for 10 cycles of distinct instructions -> count stays 1, outputs appear in order with 1-cycle delay; assert rst_n=0 mid-stream -> out_valid=0 and illegal_cnt=0 immediately.
